// File: rtl/kbd_pkg.sv
// Shared types and default scan codes for the keyboard command encoder.
package kbd_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DELAY = 2'b01,
        ST_RATE  = 2'b10
    } rep_state_e;

    localparam int unsigned KBD_IDX_W = 4;

    typedef struct packed {
        logic [KBD_IDX_W-1:0] idx;
        evt_type_e            typ;
    } evt_t;

    localparam logic [8:0] KC_SPACE = 9'h029;
    localparam logic [8:0] KC_A     = 9'h01C;
    localparam logic [8:0] KC_D     = 9'h023;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Show-ahead synchronous event FIFO; the head output holds the last popped
// entry while empty.
module kbd_evt_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is taken.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        hold_d = hold_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d   = rd_q + 1'b1;
            hold_d = mem_q[rd_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/key_cmd_encoder.sv
// Maps decoder key changes onto press/release/repeat game commands and
// buffers them in a valid/ready FIFO with sticky overflow.
module key_cmd_encoder
    import kbd_pkg::*;
#(
    parameter int unsigned           NUM_KEYS     = 3,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES    = {KC_D, KC_A, KC_SPACE},
    parameter int unsigned           REPEAT_DELAY = 50_000_000,
    parameter int unsigned           REPEAT_RATE  = 10_000_000,
    parameter int unsigned           FIFO_DEPTH   = 8,
    localparam int unsigned          IW           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [511:0]        key_down,
    input  logic [8:0]          last_change,
    input  logic                key_valid,
    input  logic                repeat_en,
    input  logic                ovf_clr,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [IW-1:0]       cmd_idx,
    output logic [1:0]          cmd_type,
    output logic [NUM_KEYS-1:0] held,
    output logic                overflow
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned DW      = IW + 2;

    logic              lk_hit;
    logic [IW-1:0]     lk_idx;
    logic              s1_hit_q;
    logic [IW-1:0]     s1_idx_q;
    evt_type_e         s1_type_q;
    logic [NUM_KEYS-1:0] held_q, held_d;

    rep_state_e        st_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     rep_key_q;
    logic              rep_req;
    logic              press_wr;

    logic              push;
    logic [DW-1:0]     push_data;
    logic [DW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic              overflow_q;

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!lk_hit && (last_change == KEY_CODES[9*i +: 9])) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
        end
    end

    always_comb begin
        held_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            held_d[i] = key_down[KEY_CODES[9*i +: 9]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_hit_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_type_q <= EVT_NONE;
            held_q    <= '0;
        end else begin
            s1_hit_q  <= key_valid && lk_hit;
            s1_idx_q  <= lk_idx;
            s1_type_q <= key_down[last_change] ? EVT_PRESS : EVT_RELEASE;
            held_q    <= held_d;
        end
    end

    assign press_wr = s1_hit_q && (s1_type_q == EVT_PRESS);
    // The tick is raised on the counter alone, so a repeat due in the same
    // cycle the held bit drops is still emitted.
    assign rep_req  = repeat_en && (st_q != ST_IDLE) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            rep_key_q <= '0;
        end else if (!repeat_en) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
        end else if (press_wr) begin
            st_q      <= ST_DELAY;
            cnt_q     <= CW'(REPEAT_DELAY - 1);
            rep_key_q <= s1_idx_q;
        end else if (st_q != ST_IDLE) begin
            if (!held_q[rep_key_q]) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
            end else if (cnt_q == '0) begin
                st_q  <= ST_RATE;
                cnt_q <= CW'(REPEAT_RATE - 1);
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Key events take the write port; a coincident repeat tick is discarded.
    assign push      = s1_hit_q || rep_req;
    assign push_data = s1_hit_q ? {s1_idx_q, s1_type_q} : {rep_key_q, EVT_REPEAT};
    assign pop       = cmd_valid && cmd_ready;
    assign drop      = push && fifo_full && !pop;

    kbd_evt_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_data),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign cmd_valid = !fifo_empty;
    assign cmd_idx   = head[DW-1:2];
    assign cmd_type  = head[1:0];
    assign held      = held_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_cmd_encoder.sv
// Directed bench for key_cmd_encoder with short repeat timings and a 4-deep FIFO.
module tb_key_cmd_encoder;
    import kbd_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         repeat_en;
    logic         ovf_clr;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_idx;
    logic [1:0]   cmd_type;
    logic [2:0]   held;
    logic         overflow;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic         any_valid;
    logic         exp_v;

    always #5 clk = ~clk;

    key_cmd_encoder #(
        .NUM_KEYS     (3),
        .KEY_CODES    ({KC_D, KC_A, KC_SPACE}),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .repeat_en   (repeat_en),
        .ovf_clr     (ovf_clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_idx     (cmd_idx),
        .cmd_type    (cmd_type),
        .held        (held),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [8:0] code, input logic down);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
        tick();
        key_valid      = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [1:0] idx, input evt_type_e typ);
        check({tag, "_v"}, cmd_valid, 1'b1);
        check({tag, "_idx"}, cmd_idx, idx);
        check({tag, "_type"}, cmd_type, typ);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_down = '0; last_change = '0; key_valid = 1'b0;
        repeat_en = 1'b0; ovf_clr = 1'b0; cmd_ready = 1'b0;
        tick(); tick();
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_idx", cmd_idx, 2'd0);
        check("rst_type", cmd_type, 2'b00);
        check("rst_held", held, 3'b000);
        check("rst_ovf", overflow, 1'b0);
        rst = 1'b1;
        tick();

        // press then release, no repeat
        pulse(KC_A, 1'b1);
        check("pr_held", held, 3'b010);
        check("pr_lat1", cmd_valid, 1'b0);
        tick();
        expect_pop("press_a", 2'd1, EVT_PRESS);
        check("pr_empty", cmd_valid, 1'b0);
        pulse(KC_A, 1'b0);
        check("rel_held", held, 3'b000);
        tick();
        expect_pop("rel_a", 2'd1, EVT_RELEASE);

        // unmapped code
        pulse(9'h015, 1'b1);
        any_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            any_valid |= cmd_valid;
            tick();
        end
        check("unmapped", any_valid, 1'b0);
        key_down[9'h015] = 1'b0;

        // typematic repeat on d
        repeat_en = 1'b1;
        cmd_ready = 1'b1;
        pulse(KC_D, 1'b1);
        tick();
        check("rep_press_v", cmd_valid, 1'b1);
        check("rep_press_idx", cmd_idx, 2'd2);
        check("rep_press_type", cmd_type, EVT_PRESS);
        for (int k = 2; k <= 31; k++) begin
            tick();
            exp_v = (k == 21) || (k == 26) || (k == 31);
            check($sformatf("rep_v_%0d", k), cmd_valid, exp_v);
            if (exp_v) begin
                check($sformatf("rep_idx_%0d", k), cmd_idx, 2'd2);
                check($sformatf("rep_type_%0d", k), cmd_type, EVT_REPEAT);
            end
        end
        pulse(KC_D, 1'b0);
        check("rep_rel_gap", cmd_valid, 1'b0);
        tick();
        check("rep_rel_v", cmd_valid, 1'b1);
        check("rep_rel_idx", cmd_idx, 2'd2);
        check("rep_rel_type", cmd_type, EVT_RELEASE);
        any_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            any_valid |= cmd_valid;
        end
        check("rep_stopped", any_valid, 1'b0);

        // overflow with a 4-deep FIFO
        repeat_en = 1'b0;
        cmd_ready = 1'b0;
        pulse(KC_SPACE, 1'b1);
        pulse(KC_A, 1'b1);
        pulse(KC_D, 1'b1);
        pulse(KC_SPACE, 1'b1);
        pulse(KC_A, 1'b1);
        tick(); tick();
        check("ovf_set", overflow, 1'b1);
        check("ovf_head", cmd_idx, 2'd0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", overflow, 1'b0);
        // write into a full FIFO while popping is accepted
        pulse(KC_D, 1'b1);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        check("fullpop_ovf", overflow, 1'b0);
        check("fullpop_head", cmd_idx, 2'd1);
        // clear and drop in the same cycle keeps overflow
        pulse(KC_SPACE, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("clr_drop_ovf", overflow, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr2", overflow, 1'b0);
        expect_pop("drain0", 2'd1, EVT_PRESS);
        expect_pop("drain1", 2'd2, EVT_PRESS);
        expect_pop("drain2", 2'd0, EVT_PRESS);
        expect_pop("drain3", 2'd2, EVT_PRESS);
        check("drain_empty", cmd_valid, 1'b0);
        key_down = '0;
        tick(); tick();

        // reset mid-operation
        repeat_en = 1'b1;
        pulse(KC_D, 1'b1);
        pulse(KC_A, 1'b1);
        pulse(KC_SPACE, 1'b1);
        tick(); tick();
        check("mid_queued", cmd_valid, 1'b1);
        rst = 1'b0; tick();
        check("mid_rst_valid", cmd_valid, 1'b0);
        check("mid_rst_held", held, 3'b000);
        check("mid_rst_idx", cmd_idx, 2'd0);
        check("mid_rst_type", cmd_type, 2'b00);
        check("mid_rst_ovf", overflow, 1'b0);
        rst = 1'b1;
        any_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            any_valid |= cmd_valid;
        end
        check("mid_no_rep", any_valid, 1'b0);
        check("mid_held_back", held, 3'b111);
        key_down = '0;
        tick(); tick();

        // repeat tick collides with a space press write
        cmd_ready = 1'b1;
        pulse(KC_D, 1'b1);
        tick();
        check("col_press_d", cmd_idx, 2'd2);
        check("col_press_d_v", cmd_valid, 1'b1);
        for (int k = 2; k <= 19; k++) tick();
        pulse(KC_SPACE, 1'b1);
        tick();
        check("col_v", cmd_valid, 1'b1);
        check("col_idx", cmd_idx, 2'd0);
        check("col_type", cmd_type, EVT_PRESS);
        check("col_ovf", overflow, 1'b0);
        for (int k = 22; k <= 41; k++) begin
            tick();
            exp_v = (k == 41);
            check($sformatf("col_v_%0d", k), cmd_valid, exp_v);
            if (exp_v) begin
                check("col_rep_idx", cmd_idx, 2'd0);
                check("col_rep_type", cmd_type, EVT_REPEAT);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_cmd_encoder.md
# key_cmd_encoder

Parametrised successor to the fixed three-key mapper. It sits directly after `KeyboardDecoder` and turns its `key_down`/`last_change`/`key_valid` outputs into a buffered stream of game commands. It supports a configurable key table, distinct press, release and typematic-repeat events, a live held-key mask, and a valid/ready output FIFO with sticky overflow.

## Interface

Parameters:
- `NUM_KEYS`, 3: number of mapped keys, 1..16.
- `KEY_CODES`, {9'h023, 9'h01C, 9'h029}: packed `[NUM_KEYS*9-1:0]`; entry i at bits `[9i+8:9i]`. Defaults: i=0 space/start, 1 a/left, 2 d/right.
- `REPEAT_DELAY`, 50_000_000: cycles from press to first repeat; ≥2.
- `REPEAT_RATE`, 10_000_000: cycles between repeats; ≥2.
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, ≥2.

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: synchronous reset, active-low. Sampled on the `clk` rising edge; low = reset.
- `key_down` input 512: held-key vector from the decoder.
- `last_change` input 9: scan code of the most recent change.
- `key_valid` input 1: one-cycle pulse when `last_change` is updated.
- `repeat_en` input 1: enables typematic repeat.
- `ovf_clr` input 1: clears `overflow`.
- `cmd_valid` output 1: FIFO head is valid.
- `cmd_ready` input 1: consumer accepts the head.
- `cmd_idx` output `$clog2(NUM_KEYS)` (min 1): key table index of the head.
- `cmd_type` output 2: 01 PRESS, 10 RELEASE, 11 REPEAT.
- `held` output `NUM_KEYS`: `held[i] = key_down[KEY_CODES[i]]`, registered.
- `overflow` output 1: sticky; set when an event is dropped.

## Operation

- **Lookup.** On `key_valid`, compare `last_change` against every table entry. The lowest matching index wins. No match means the event is ignored.
- **Event classification.** Type is PRESS if `key_down[last_change]`=1, otherwise RELEASE.
- **Lookup register.** Stage 1 registers {hit, idx, type}. The FIFO write occurs in the following cycle.
- **Repeat FSM states:** IDLE, DELAY, RATE.
  - Any PRESS write for key i, in any state: load `rep_key`=i and counter=`REPEAT_DELAY`-1, go to DELAY.
  - DELAY or RATE: the counter decrements each cycle. At 0, request a REPEAT for `rep_key`, reload `REPEAT_RATE`-1, go to RATE.
  - Any state goes to IDLE when `held[rep_key]`=0 or `repeat_en`=0.
  - A RELEASE of a different key does not affect the FSM.
- **Simultaneous key write and repeat request.** The key event is written. The repeat is dropped, does not count as overflow, and the counter reloads normally.
- **FIFO behaviour.**
  - Write when full and `cmd_ready`=0: event dropped, `overflow` set.
  - Full with a simultaneous pop: the write is accepted.
  - Empty: `cmd_valid`=0. `cmd_idx` and `cmd_type` hold their last value and are don't-care.
  - Pointers are `$clog2(FIFO_DEPTH)`+1 bits wide and wrap naturally; full and empty are decided by comparing the MSB.
- **`overflow`.** If `ovf_clr` and a new drop occur in the same cycle, `overflow` stays 1.
- **Reset** (`rst`=0), all synchronous:
  - FIFO emptied; `cmd_valid`=0, `cmd_idx`=0, `cmd_type`=00.
  - `held`=0, `overflow`=0.
  - Repeat FSM in IDLE with counter 0; stage 1 cleared.
  - A reset mid-stream discards every queued and in-flight event.

## Timing

- `key_valid` in cycle N → stage 1 valid in N+1 → FIFO write at the end of N+1 → `cmd_valid`=1 in N+2 (empty FIFO). Latency 2.
- Pop occurs when `cmd_valid`&&`cmd_ready`; the next entry appears the following cycle. Sustained throughput is 1 event/cycle.
- `held` lags `key_down` by 1 cycle.
- First REPEAT write comes exactly `REPEAT_DELAY` cycles after the PRESS write; subsequent REPEATs every `REPEAT_RATE` cycles.
- The repeat FSM checks `held` as registered, so release stops repeat with 1 cycle of slack. A REPEAT requested in that same cycle is still written.

## Structure

- Package `kbd_pkg`:
  - Event type enum (PRESS, RELEASE, REPEAT).
  - Event struct {idx, type}.
  - Default code localparams `KC_SPACE`, `KC_A`, `KC_D`.
- Sub-module `kbd_evt_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`, ports push/full/pop/empty, same clock and reset.
- Lookup, repeat FSM and overflow logic stay in the top level.

## Test plan

- **Press then release, `repeat_en`=0.** `key_valid` with 0x01C and `key_down[0x01C]`=1 → idx 1 PRESS at N+2. Then with `key_down`=0 → idx 1 RELEASE. `held` goes 010 then 000.
- **Unmapped code.** 0x015 pulse → no event, `cmd_valid` stays 0.
- **Repeat.** `REPEAT_DELAY`=20, `REPEAT_RATE`=5; hold d → PRESS, then REPEATs at +20, +25, +30. Release → RELEASE event, no further REPEAT.
- **Overflow.** `FIFO_DEPTH`=4, `cmd_ready`=0, 5 press events → 4 queued, `overflow`=1. Drain → events in order. `ovf_clr` → `overflow`=0.
- **Reset mid-operation.** Assert `rst`=0 with 3 queued events and repeat active → next cycle `cmd_valid`=0, `held`=0, no REPEAT after release of reset.
- **Collision.** Schedule a repeat tick in the same cycle as a space PRESS write → only the PRESS idx 0 is written, `overflow` stays 0, and repeat restarts on key 0.
